scarv_cop_malu_issue: RTL and testbench
=======================================

Name: scarv_cop_malu_issue

Overview:
- Initiator side of the COP multi-precision ALU handshake (ivalid/idone, rs1-3, imm, class, subclass, ben/wdata).
- Accepts one decoded MP/shift instruction from the COP decode stage and holds operands stable while driving malu_ivalid until malu_idone.
- Commits the returned byte-enabled result to the CPR write port, then returns a completion/error response to the core.
- A watchdog aborts hung operations.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles malu_ivalid may stay high without malu_idone before abort (range 2..255).

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  asynchronous active-low reset
- flush  in  1  abandon in-flight operation
- id_valid  in  1  decoded instruction valid
- id_ready  out  1  block can accept instruction
- id_rs1, id_rs2, id_rs3  in  32 each  source operands
- id_imm  in  32  immediate
- id_class  in  3  instruction class
- id_subclass  in  4  instruction subclass
- id_crd  in  4  destination CPR index
- malu_ivalid  out  1  instruction valid to MALU
- malu_idone  in  1  MALU instruction complete
- malu_rs1, malu_rs2, malu_rs3  out  32 each  latched operands
- malu_imm  out  32  latched immediate
- malu_class  out  3  latched class
- malu_subclass  out  4  latched subclass
- malu_cpr_rd_ben  in  4  MALU writeback byte enable
- malu_cpr_rd_wdata  in  32  MALU writeback data
- cpr_wen  out  1  CPR write strobe
- cpr_waddr  out  4  CPR write index
- cpr_wben  out  4  CPR byte enables
- cpr_wdata  out  32  CPR write data
- rsp_valid  out  1  completion response valid
- rsp_ready  in  1  core accepts response
- rsp_error  out  1  1 = timed out, no write

Behaviour:
- Reset (async, g_resetn=0):
  - State goes to IDLE; watchdog counter clears.
  - All registered outputs go to 0: malu_* operand outputs, malu_ivalid, cpr_wen, cpr_waddr, cpr_wben, cpr_wdata, rsp_valid, rsp_error.
  - Reset mid-operation discards everything; no write, no response.
- id_ready = (state==IDLE) & !flush, combinational. It is 1 immediately after reset release.
- FSM states: IDLE, BUSY, WRITE, RESP.
- IDLE:
  - On id_valid & id_ready: latch rs1-3, imm, class, subclass, crd; clear counter; go to BUSY.
- BUSY:
  - malu_ivalid=1; operand outputs constant for the whole state.
  - Counter increments every cycle.
  - malu_idone=1: capture ben/wdata, go to WRITE; malu_ivalid drops the next cycle.
  - Counter reaching TIMEOUT_CYCLES-1 without idone: go to RESP with error flag set.
  - idone and timeout in the same cycle: idone wins.
  - flush=1: go to IDLE with no write and no response; idone in the same cycle is ignored.
- WRITE (exactly one cycle):
  - cpr_wen = |captured_ben; cpr_waddr=crd; cpr_wben=captured_ben; cpr_wdata=captured_wdata.
  - ben==0 gives no write, but the cycle is still spent.
  - Go to RESP. flush is ignored (commit point passed).
- RESP:
  - rsp_valid=1 with rsp_error held stable until rsp_ready; then go to IDLE and clear the error flag.
  - flush is ignored.
- Latency, accept edge at cycle 0:
  - malu_ivalid high cycles 1..n.
  - idone seen at cycle n gives cpr_wen at n+1 and rsp_valid from n+2.
  - Minimum accept-to-response is 3 cycles.
  - No back-to-back overlap: next accept only after the RESP handshake.
- malu_idone in IDLE, WRITE or RESP is ignored.
- cpr_wen never asserts in any state other than WRITE.

Test Plan:
- Accept rs1=0x11111111, rs2=0x22222222, rs3=0x3, imm=0x5, class=3, subclass=2, crd=7; idone at cycle 1 with ben=0xF, wdata=0xDEADBEEF -> cycle 2: cpr_wen=1, waddr=7, wben=0xF, wdata=0xDEADBEEF; cycle 3: rsp_valid=1, rsp_error=0.
- MALU stalls: idone after 10 cycles with ben=0x3 -> malu_ivalid high exactly 10 cycles, operands stable throughout; single write with wben=0x3; rsp_ready held low 4 cycles keeps rsp_valid=1 and blocks id_ready.
- TIMEOUT_CYCLES=8, idone never asserts -> ivalid high 8 cycles; no cpr_wen; rsp_valid=1, rsp_error=1. Repeat with idone on the 8th cycle -> a write occurs and rsp_error=0.
- Flush at BUSY cycle 3 with idone asserted simultaneously -> no cpr_wen, no rsp_valid; id_ready=1 the next cycle (flush low).
- Reset asserted during WRITE -> cpr_wen falls asynchronously; all outputs 0; after release id_ready=1 and the next instruction completes normally.
- idone=1 with ben=0x0 -> cpr_wen stays 0; rsp_valid asserted at the usual cycle with rsp_error=0.

Source files
------------

// File: rtl/scarv_cop_malu_issue.sv
// ---------------------------------------------------------------------------
// scarv_cop_malu_issue
//
// Initiator side of the COP multi-precision ALU handshake. It takes one
// decoded MP/shift instruction, holds its operands steady while malu_ivalid
// is high, commits the byte-enabled result to the CPR write port for exactly
// one cycle and then offers a completion/error response to the core.
// A watchdog aborts an operation the MALU never acknowledges.
//
// All outputs except id_ready are registered. Each one is computed from the
// next state, so it lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module scarv_cop_malu_issue #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_rs1,
    input  logic [31:0] id_rs2,
    input  logic [31:0] id_rs3,
    input  logic [31:0] id_imm,
    input  logic [2:0]  id_class,
    input  logic [3:0]  id_subclass,
    input  logic [3:0]  id_crd,

    output logic        malu_ivalid,
    input  logic        malu_idone,
    output logic [31:0] malu_rs1,
    output logic [31:0] malu_rs2,
    output logic [31:0] malu_rs3,
    output logic [31:0] malu_imm,
    output logic [2:0]  malu_class,
    output logic [3:0]  malu_subclass,
    input  logic [3:0]  malu_cpr_rd_ben,
    input  logic [31:0] malu_cpr_rd_wdata,

    output logic        cpr_wen,
    output logic [3:0]  cpr_waddr,
    output logic [3:0]  cpr_wben,
    output logic [31:0] cpr_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Last BUSY cycle count before the watchdog fires. The counter is 0 in
    // the first BUSY cycle, so malu_ivalid is high for TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Control state
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // Latched instruction fields
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] rs3_q, rs3_d;
    logic [31:0] imm_q, imm_d;
    logic [2:0]  class_q, class_d;
    logic [3:0]  subclass_q, subclass_d;
    logic [3:0]  crd_q, crd_d;

    // Captured MALU result
    logic [3:0]  ben_q, ben_d;
    logic [31:0] res_q, res_d;

    // Registered outputs
    logic        malu_ivalid_q, malu_ivalid_d;
    logic        cpr_wen_q, cpr_wen_d;
    logic [3:0]  cpr_waddr_q, cpr_waddr_d;
    logic [3:0]  cpr_wben_q, cpr_wben_d;
    logic [31:0] cpr_wdata_q, cpr_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;

    logic        accept;
    logic        timeout_hit;

    // A flush in the same cycle as an offer must not let it in.
    assign id_ready    = (state_q == ST_IDLE) & ~flush;
    assign accept      = id_valid & id_ready;
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    // Next-state logic: handshake sequencing, watchdog and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ben_d   = ben_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // Priority: flush abandons everything (a simultaneous idone
                // is dropped), then idone beats a same-cycle timeout.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (malu_idone) begin
                    state_d = ST_WRITE;
                    ben_d   = malu_cpr_rd_ben;
                    res_d   = malu_cpr_rd_wdata;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end

            // Commit point has passed: flush is not looked at from here on.
            ST_WRITE: begin
                state_d = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction fields are captured only on the accept cycle, so the MALU
    // sees constant operands for the whole BUSY period.
    always_comb begin
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        imm_d      = imm_q;
        class_d    = class_q;
        subclass_d = subclass_q;
        crd_d      = crd_q;
        if (accept) begin
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs3_d      = id_rs3;
            imm_d      = id_imm;
            class_d    = id_class;
            subclass_d = id_subclass;
            crd_d      = id_crd;
        end
    end

    // Output decode from the next state so outputs are glitch-free flops
    always_comb begin
        malu_ivalid_d = (state_d == ST_BUSY);
        cpr_wen_d     = 1'b0;
        cpr_waddr_d   = 4'd0;
        cpr_wben_d    = 4'd0;
        cpr_wdata_d   = 32'd0;
        rsp_valid_d   = (state_d == ST_RESP);
        rsp_error_d   = (state_d == ST_RESP) & err_d;
        if (state_d == ST_WRITE) begin
            // An all-zero byte enable still spends the WRITE cycle but
            // must not strobe the register file.
            cpr_wen_d   = |ben_d;
            cpr_waddr_d = crd_q;
            cpr_wben_d  = ben_d;
            cpr_wdata_d = res_d;
        end
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            err_q         <= 1'b0;
            rs1_q         <= 32'd0;
            rs2_q         <= 32'd0;
            rs3_q         <= 32'd0;
            imm_q         <= 32'd0;
            class_q       <= 3'd0;
            subclass_q    <= 4'd0;
            crd_q         <= 4'd0;
            ben_q         <= 4'd0;
            res_q         <= 32'd0;
            malu_ivalid_q <= 1'b0;
            cpr_wen_q     <= 1'b0;
            cpr_waddr_q   <= 4'd0;
            cpr_wben_q    <= 4'd0;
            cpr_wdata_q   <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rs3_q         <= rs3_d;
            imm_q         <= imm_d;
            class_q       <= class_d;
            subclass_q    <= subclass_d;
            crd_q         <= crd_d;
            ben_q         <= ben_d;
            res_q         <= res_d;
            malu_ivalid_q <= malu_ivalid_d;
            cpr_wen_q     <= cpr_wen_d;
            cpr_waddr_q   <= cpr_waddr_d;
            cpr_wben_q    <= cpr_wben_d;
            cpr_wdata_q   <= cpr_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

    assign malu_ivalid   = malu_ivalid_q;
    assign malu_rs1      = rs1_q;
    assign malu_rs2      = rs2_q;
    assign malu_rs3      = rs3_q;
    assign malu_imm      = imm_q;
    assign malu_class    = class_q;
    assign malu_subclass = subclass_q;
    assign cpr_wen       = cpr_wen_q;
    assign cpr_waddr     = cpr_waddr_q;
    assign cpr_wben      = cpr_wben_q;
    assign cpr_wdata     = cpr_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_scarv_cop_malu_issue.sv
// ---------------------------------------------------------------------------
// Testbench for scarv_cop_malu_issue.
// Each transaction is described by when idone arrives, when (if ever) a flush
// hits, the result byte enables and how long the core stalls the response.
// The reference model turns that into an outcome (flush / write / timeout)
// and the cycle the BUSY period ends, and every output is checked each cycle.
// ---------------------------------------------------------------------------
module tb_scarv_cop_malu_issue;

    localparam int T = 12;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_rs1 = '0, id_rs2 = '0, id_rs3 = '0, id_imm = '0;
    logic [2:0]  id_class = '0;
    logic [3:0]  id_subclass = '0, id_crd = '0;
    logic        malu_ivalid;
    logic        malu_idone = 1'b0;
    logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_imm;
    logic [2:0]  malu_class;
    logic [3:0]  malu_subclass;
    logic [3:0]  malu_cpr_rd_ben = '0;
    logic [31:0] malu_cpr_rd_wdata = '0;
    logic        cpr_wen;
    logic [3:0]  cpr_waddr, cpr_wben;
    logic [31:0] cpr_wdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_malu_issue #(.TIMEOUT_CYCLES(T)) dut (
        .g_clk             (g_clk),
        .g_resetn          (g_resetn),
        .flush             (flush),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_rs3            (id_rs3),
        .id_imm            (id_imm),
        .id_class          (id_class),
        .id_subclass       (id_subclass),
        .id_crd            (id_crd),
        .malu_ivalid       (malu_ivalid),
        .malu_idone        (malu_idone),
        .malu_rs1          (malu_rs1),
        .malu_rs2          (malu_rs2),
        .malu_rs3          (malu_rs3),
        .malu_imm          (malu_imm),
        .malu_class        (malu_class),
        .malu_subclass     (malu_subclass),
        .malu_cpr_rd_ben   (malu_cpr_rd_ben),
        .malu_cpr_rd_wdata (malu_cpr_rd_wdata),
        .cpr_wen           (cpr_wen),
        .cpr_waddr         (cpr_waddr),
        .cpr_wben          (cpr_wben),
        .cpr_wdata         (cpr_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_error         (rsp_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ivalid"}, 32'(malu_ivalid), 32'd0);
        check({tag, "_rs1"},    malu_rs1, 32'd0);
        check({tag, "_rs2"},    malu_rs2, 32'd0);
        check({tag, "_rs3"},    malu_rs3, 32'd0);
        check({tag, "_imm"},    malu_imm, 32'd0);
        check({tag, "_cls"},    32'({malu_class, malu_subclass}), 32'd0);
        check({tag, "_wen"},    32'(cpr_wen), 32'd0);
        check({tag, "_waddr"},  32'({cpr_waddr, cpr_wben}), 32'd0);
        check({tag, "_wdata"},  cpr_wdata, 32'd0);
        check({tag, "_rsp"},    32'({rsp_valid, rsp_error}), 32'd0);
    endtask

    // n: idone cycle (0 or >T = never inside BUSY), f: flush cycle (0 = none),
    // w: cycles the core holds rsp_ready low, noise: random don't-care inputs.
    task automatic run_txn(input int n, input int f, input logic [3:0] ben,
                           input logic [31:0] wd, input int w, input bit noise,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input logic [31:0] im,
                           input logic [2:0] cl, input logic [3:0] sc,
                           input logic [3:0] crd);
        int  e;          // last cycle malu_ivalid is high
        int  outcome;    // 0 flushed, 1 written, 2 timed out
        int  s;          // first rsp_valid cycle
        int  last;       // first cycle back in IDLE
        int  ivalid_cnt;
        int  wen_cnt;
        bit  exp_wen, exp_rv;

        // Reference model
        e = T;
        outcome = 2;
        if (n >= 1 && n <= T) begin
            e = n;
            outcome = 1;
        end
        if (f >= 1 && f <= e) begin
            e = f;
            outcome = 0;
        end
        s    = (outcome == 1) ? e + 2 : e + 1;
        last = (outcome == 0) ? e + 1 : s + w + 1;
        ivalid_cnt = 0;
        wen_cnt = 0;

        // Cycle 0: offer the instruction
        @(negedge g_clk);
        flush = 1'b0;
        malu_idone = 1'b0;
        rsp_ready = 1'b0;
        id_valid = 1'b1;
        id_rs1 = r1; id_rs2 = r2; id_rs3 = r3; id_imm = im;
        id_class = cl; id_subclass = sc; id_crd = crd;
        #1;
        check("id_ready_idle", 32'(id_ready), 32'd1);

        for (int c = 1; c <= last; c++) begin
            @(negedge g_clk);
            // Drive this cycle's inputs
            id_valid = (noise && c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            id_rs1 = $urandom; id_rs2 = $urandom;
            id_rs3 = $urandom; id_imm = $urandom;
            id_class = 3'($urandom); id_subclass = 4'($urandom); id_crd = 4'($urandom);
            if (c <= e)
                malu_idone = (c == n);
            else
                malu_idone = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == n && c <= e) begin
                malu_cpr_rd_ben = ben;
                malu_cpr_rd_wdata = wd;
            end else begin
                malu_cpr_rd_ben = 4'($urandom);
                malu_cpr_rd_wdata = $urandom;
            end
            if (c <= e)
                flush = (c == f);
            else if (noise && c < last)
                flush = 1'($urandom_range(0, 1));
            else
                flush = 1'b0;
            if (outcome != 0 && c >= s && c < last)
                rsp_ready = (c >= s + w);
            else if (noise && c < s)
                rsp_ready = 1'($urandom_range(0, 1));
            else
                rsp_ready = 1'b0;
            #1;

            // Compare against the model
            check("ivalid", 32'(malu_ivalid), 32'(c <= e));
            if (malu_ivalid) ivalid_cnt++;
            if (c <= e) begin
                check("op_rs1", malu_rs1, r1);
                check("op_rs2", malu_rs2, r2);
                check("op_rs3", malu_rs3, r3);
                check("op_imm", malu_imm, im);
                check("op_cls", 32'({malu_class, malu_subclass}), 32'({cl, sc}));
            end
            exp_wen = (outcome == 1) && (c == e + 1) && (ben != 4'd0);
            check("cpr_wen", 32'(cpr_wen), 32'(exp_wen));
            if (cpr_wen) wen_cnt++;
            if (exp_wen) begin
                check("cpr_waddr", 32'(cpr_waddr), 32'(crd));
                check("cpr_wben",  32'(cpr_wben),  32'(ben));
                check("cpr_wdata", cpr_wdata, wd);
            end
            exp_rv = (outcome != 0) && (c >= s) && (c <= s + w);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv)
                check("rsp_error", 32'(rsp_error), 32'(outcome == 2));
            check("id_ready", 32'(id_ready), 32'(c == last));
        end
        check("ivalid_cycles", 32'(ivalid_cnt), 32'(e));
        check("wen_count", 32'(wen_cnt), 32'((outcome == 1 && ben != 4'd0) ? 1 : 0));
        $display("txn n=%0d f=%0d ben=%h w=%0d outcome=%0s busy=%0d", n, f, ben, w,
                 (outcome == 0) ? "flush" : (outcome == 1) ? "write" : "timeout", e);
        id_valid = 1'b0;
        flush = 1'b0;
        malu_idone = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic run_rand(input int n, input int f, input logic [3:0] ben, input int w, input bit noise);
        run_txn(n, f, ben, $urandom, w, noise, $urandom, $urandom, $urandom, $urandom,
                3'($urandom), 4'($urandom), 4'($urandom));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge g_clk);
        check_all_zero("reset");
        check("reset_id_ready", 32'(id_ready), 32'd1);
        g_resetn = 1'b1;
        #1;
        check("release_id_ready", 32'(id_ready), 32'd1);

        // Basic operation, idone in the first BUSY cycle
        run_txn(1, 0, 4'hF, 32'hDEADBEEF, 0, 1'b0, 32'h11111111, 32'h22222222,
                32'h3, 32'h5, 3'd3, 4'd2, 4'd7);
        // MALU stall for 10 cycles, response stalled 4 cycles
        run_rand(10, 0, 4'h3, 4, 1'b0);
        // Watchdog with no idone, then idone in the final allowed cycle
        run_rand(0, 0, 4'hF, 2, 1'b0);
        run_rand(T, 0, 4'hA, 1, 1'b0);
        // Flush colliding with idone
        run_rand(3, 3, 4'hF, 0, 1'b0);
        // Zero byte enables: no write, normal response
        run_rand(2, 0, 4'h0, 0, 1'b0);

        // Reset asserted during the WRITE cycle
        @(negedge g_clk);
        id_valid = 1'b1;
        id_rs1 = 32'hCAFEF00D; id_crd = 4'd9;
        @(negedge g_clk);
        id_valid = 1'b0;
        malu_idone = 1'b1;
        malu_cpr_rd_ben = 4'hF;
        malu_cpr_rd_wdata = 32'h12345678;
        @(negedge g_clk);
        malu_idone = 1'b0;
        #1;
        check("wr_before_reset", 32'(cpr_wen), 32'd1);
        g_resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        check("post_reset_id_ready", 32'(id_ready), 32'd1);
        check("post_reset_rsp", 32'(rsp_valid), 32'd0);
        $display("txn reset-during-write done");
        run_rand(4, 0, 4'h5, 1, 1'b0);

        // Randomized traffic with don't-care noise on ignored inputs
        for (int i = 0; i < 150; i++) begin
            run_rand($urandom_range(0, T + 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, T + 2) : 0,
                     4'($urandom), $urandom_range(0, 4), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
